// File: rtl/nbload_tag_ctl_pkg.sv
// nbload_types: shared entry state encoding and entry record for the
// non-blocking load tag controller.
package nbload_types;

   localparam int NBL_DEPTH = 8;

   typedef enum logic [1:0] {
      FREE = 2'b00,
      PEND = 2'b01,
      DONE = 2'b10
   } nbl_state_e;

   typedef struct packed {
      nbl_state_e state;
      logic       wb;
      logic       err;
      logic [4:0] rd;
   } nbl_entry_t;

   localparam nbl_entry_t NBL_ENTRY_FREE = '{state: FREE, wb: 1'b0, err: 1'b0, rd: 5'd0};

endpackage

// File: rtl/nbload_tag_ctl_if.sv
// nbload_tag_ctl_if: allocation, response, writeback, hazard and status
// signals of the load tag controller. The stats outputs and stats_clr only
// exist when NBLOAD_STATS_EN is defined.
interface nbload_tag_ctl_if #(
   parameter int DEPTH = nbload_types::NBL_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
);
   logic             alloc_valid;
   logic [4:0]       alloc_rd;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             rsp_valid;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err;
   logic             wb_valid;
   logic             wb_ready;
   logic [TAG_W-1:0] wb_tag;
   logic [4:0]       wb_rd;
   logic             wb_err;
   logic [4:0]       rd_check;
   logic             rd_hit;
   logic             flush;
   logic             unexp_rsp;
   logic [TAG_W:0]   free_cnt;
`ifdef NBLOAD_STATS_EN
   logic             stats_clr;
   logic [15:0]      stall_cnt;
   logic [TAG_W:0]   max_occ;

   modport slave (
      input  alloc_valid, alloc_rd, rsp_valid, rsp_tag, rsp_err, wb_ready, rd_check, flush, stats_clr,
      output alloc_ready, alloc_tag, wb_valid, wb_tag, wb_rd, wb_err, rd_hit, unexp_rsp, free_cnt,
             stall_cnt, max_occ
   );
   modport master (
      output alloc_valid, alloc_rd, rsp_valid, rsp_tag, rsp_err, wb_ready, rd_check, flush, stats_clr,
      input  alloc_ready, alloc_tag, wb_valid, wb_tag, wb_rd, wb_err, rd_hit, unexp_rsp, free_cnt,
             stall_cnt, max_occ
   );
`else
   modport slave (
      input  alloc_valid, alloc_rd, rsp_valid, rsp_tag, rsp_err, wb_ready, rd_check, flush,
      output alloc_ready, alloc_tag, wb_valid, wb_tag, wb_rd, wb_err, rd_hit, unexp_rsp, free_cnt
   );
   modport master (
      output alloc_valid, alloc_rd, rsp_valid, rsp_tag, rsp_err, wb_ready, rd_check, flush,
      input  alloc_ready, alloc_tag, wb_valid, wb_tag, wb_rd, wb_err, rd_hit, unexp_rsp, free_cnt
   );
`endif
endinterface

// File: rtl/nbload_tag_ctl_rr_arb.sv
// nbload_rr_arb: round-robin pick among requesters starting at ptr. While
// lock is asserted the previous pick is held for as long as it keeps
// requesting, so a stalled writeback does not change under the consumer.
module nbload_rr_arb #(
   parameter int DEPTH = 8,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] req,
   input  logic [TAG_W-1:0] ptr,
   input  logic             lock,
   output logic [DEPTH-1:0] grant,
   output logic [TAG_W-1:0] idx,
   output logic             valid
);
   logic             lock_q;
   logic [TAG_W-1:0] held_q;
   logic [TAG_W-1:0] cand;
   logic             found;

   // held pick wins while still requesting, else first requester at or after ptr
   always_comb begin
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      if (lock_q && req[held_q]) begin
         idx   = held_q;
         found = 1'b1;
      end
      for (int k = 0; k < DEPTH; k++) begin
         cand = ptr + TAG_W'(k);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      valid = found;
      grant = found ? (DEPTH'(1) << idx) : '0;
   end

   // remember the current pick for the next cycle when the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q <= 1'b0;
         held_q <= '0;
      end else begin
         lock_q <= lock;
         held_q <= idx;
      end
   end

endmodule

// File: rtl/nbload_tag_ctl.sv
// nbload_tag_ctl: tag table for outstanding non-blocking loads. Allocates
// the lowest free tag, matches bus responses, schedules register writeback
// round-robin, provides the decode rd hazard check and handles flush and
// write-after-write kill. Optional NBLOAD_STATS_EN adds stall_cnt/max_occ.
//
// entry state | meaning
// FREE        | tag available for allocation
// PEND        | load issued, waiting for the bus response
// DONE        | response returned; written back if wb=1, else dropped
module nbload_tag_ctl
   import nbload_types::*;
#(
   parameter int DEPTH = NBL_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input logic             clk,
   input logic             rst,
   nbload_tag_ctl_if.slave bus
);
   nbl_entry_t       ent_q [DEPTH];
   nbl_entry_t       ent_d [DEPTH];
   logic [DEPTH-1:0] wb_req;
   logic [DEPTH-1:0] arb_grant;
   logic [TAG_W-1:0] arb_idx;
   logic             arb_valid;
   logic [TAG_W-1:0] rr_ptr_q;
   logic [TAG_W-1:0] low_free;
   logic             any_free;
   logic             hit;
   logic             alloc_fire;
   logic             wb_fire;
   logic [TAG_W:0]   free_cnt_d;
   logic [TAG_W:0]   free_cnt_q;
   logic             unexp_q;

   // writeback requests, lowest free tag and rd hazard from the current table
   always_comb begin
      wb_req   = '0;
      low_free = '0;
      any_free = 1'b0;
      hit      = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ent_q[i].state == FREE) begin
            low_free = TAG_W'(i);
            any_free = 1'b1;
         end
         wb_req[i] = (ent_q[i].state == DONE) && ent_q[i].wb;
         if (ent_q[i].state != FREE && ent_q[i].wb && ent_q[i].rd == bus.rd_check && bus.rd_check != 5'd0)
            hit = 1'b1;
      end
   end

   assign bus.alloc_ready = any_free && !bus.flush;
   assign bus.alloc_tag   = low_free;
   assign alloc_fire      = bus.alloc_valid && any_free && !bus.flush;
   assign wb_fire         = arb_valid && bus.wb_ready;

   nbload_rr_arb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (wb_req),
      .ptr   (rr_ptr_q),
      .lock  (arb_valid && !bus.wb_ready && !bus.flush),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign bus.wb_valid  = arb_valid;
   assign bus.wb_tag    = arb_idx;
   assign bus.wb_rd     = arb_valid ? ent_q[arb_idx].rd : 5'd0;
   assign bus.wb_err    = arb_valid ? ent_q[arb_idx].err : 1'b0;
   assign bus.rd_hit    = hit;
   assign bus.unexp_rsp = unexp_q;
   assign bus.free_cnt  = free_cnt_q;

   // per-entry next state: response, flush/WAW kill, retire, then allocation
   always_comb begin
      free_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (bus.rsp_valid && bus.rsp_tag == TAG_W'(i) && ent_q[i].state == PEND) begin
            ent_d[i].state = DONE;
            ent_d[i].err   = bus.rsp_err;
         end
         if (ent_q[i].state != FREE) begin
            if (bus.flush)
               ent_d[i].wb = 1'b0;
            if (alloc_fire && bus.alloc_rd != 5'd0 && ent_q[i].rd == bus.alloc_rd)
               ent_d[i].wb = 1'b0;
         end
         if (ent_q[i].state == DONE && !ent_q[i].wb)
            ent_d[i] = NBL_ENTRY_FREE;
         if (wb_fire && arb_grant[i])
            ent_d[i] = NBL_ENTRY_FREE;
         if (alloc_fire && low_free == TAG_W'(i))
            ent_d[i] = '{state: PEND, wb: (bus.alloc_rd != 5'd0), err: 1'b0, rd: bus.alloc_rd};
         if (ent_d[i].state == FREE)
            free_cnt_d = free_cnt_d + (TAG_W+1)'(1);
      end
   end

   // table, round-robin pointer, free count and unexpected-response pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= NBL_ENTRY_FREE;
         rr_ptr_q   <= '0;
         free_cnt_q <= (TAG_W+1)'(DEPTH);
         unexp_q    <= 1'b0;
      end else begin
         ent_q      <= ent_d;
         free_cnt_q <= free_cnt_d;
         unexp_q    <= bus.rsp_valid && (ent_q[bus.rsp_tag].state != PEND);
         if (wb_fire)
            rr_ptr_q <= arb_idx + TAG_W'(1);
      end
   end

`ifdef NBLOAD_STATS_EN
   logic [15:0]    stall_cnt_q;
   logic [TAG_W:0] max_occ_q;
   logic [TAG_W:0] occ_d;

   assign occ_d         = (TAG_W+1)'(DEPTH) - free_cnt_d;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.max_occ   = max_occ_q;

   // saturating alloc stall counter and peak occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         max_occ_q   <= '0;
      end else if (bus.stats_clr) begin
         stall_cnt_q <= '0;
         max_occ_q   <= '0;
      end else begin
         if (bus.alloc_valid && !bus.alloc_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (occ_d > max_occ_q)
            max_occ_q <= occ_d;
      end
   end
`endif

endmodule

// File: tb/tb_nbload_tag_ctl.sv
// tb_nbload_tag_ctl: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the tag table.
module tb_nbload_tag_ctl;
   localparam int DEPTH = 8;
   localparam int TAG_W = 3;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   nbload_tag_ctl_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

   nbload_tag_ctl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: busy = tag allocated, back = response returned, live = will write back
   bit m_busy [DEPTH];
   bit m_back [DEPTH];
   bit m_live [DEPTH];
   bit m_err  [DEPTH];
   int m_rd   [DEPTH];
   int m_ptr;
   bit m_lock;
   int m_lock_tag;
   bit m_unexp;
   int pend [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int t = 0; t < DEPTH; t++) begin
         m_busy[t] = 0; m_back[t] = 0; m_live[t] = 0; m_err[t] = 0; m_rd[t] = 0;
      end
      m_ptr = 0; m_lock = 0; m_lock_tag = 0; m_unexp = 0;
   endtask

   function automatic bit wants_wb(int t);
      return m_busy[t] && m_back[t] && m_live[t];
   endfunction

   function automatic int model_sel();
      int s = -1;
      if (m_lock && wants_wb(m_lock_tag)) return m_lock_tag;
      for (int k = 0; k < DEPTH; k++)
         if (s < 0 && wants_wb((m_ptr + k) % DEPTH)) s = (m_ptr + k) % DEPTH;
      return s;
   endfunction

   task automatic check_outputs();
      int sel, lo, nfree;
      bit hit;
      sel = model_sel(); lo = 0; nfree = 0; hit = 0;
      for (int t = DEPTH - 1; t >= 0; t--) begin
         if (!m_busy[t]) begin lo = t; nfree++; end
         if (m_busy[t] && m_live[t] && m_rd[t] == int'(bus.rd_check) && bus.rd_check != 0) hit = 1;
      end
      chk("alloc_ready", bus.alloc_ready, 32'(nfree > 0 && !bus.flush));
      chk("alloc_tag", bus.alloc_tag, lo);
      chk("free_cnt", bus.free_cnt, nfree);
      chk("wb_valid", bus.wb_valid, 32'(sel >= 0));
      chk("wb_tag", bus.wb_tag, sel >= 0 ? sel : 0);
      chk("wb_rd", bus.wb_rd, sel >= 0 ? m_rd[sel] : 0);
      chk("wb_err", bus.wb_err, sel >= 0 ? 32'(m_err[sel]) : 0);
      chk("rd_hit", bus.rd_hit, 32'(hit));
      chk("unexp_rsp", bus.unexp_rsp, 32'(m_unexp));
   endtask

   task automatic model_edge();
      int sel, atag, rt;
      bit fire_a, fire_w, pend_hit;
      bit o_busy [DEPTH];
      bit o_back [DEPTH];
      bit o_live [DEPTH];
      sel = model_sel();
      atag = -1;
      for (int t = DEPTH - 1; t >= 0; t--) if (!m_busy[t]) atag = t;
      fire_a   = bus.alloc_valid && atag >= 0 && !bus.flush;
      fire_w   = sel >= 0 && bus.wb_ready;
      rt       = int'(bus.rsp_tag);
      pend_hit = m_busy[rt] && !m_back[rt];
      m_unexp  = bus.rsp_valid && !pend_hit;
      o_busy = m_busy; o_back = m_back; o_live = m_live;
      for (int t = 0; t < DEPTH; t++)
         if (o_busy[t] && o_back[t] && !o_live[t]) m_busy[t] = 0;
      if (fire_w) m_busy[sel] = 0;
      if (bus.rsp_valid && pend_hit) begin m_back[rt] = 1; m_err[rt] = bus.rsp_err; end
      for (int t = 0; t < DEPTH; t++)
         if (o_busy[t] && (bus.flush || (fire_a && bus.alloc_rd != 0 && m_rd[t] == int'(bus.alloc_rd))))
            m_live[t] = 0;
      if (fire_a) begin
         m_busy[atag] = 1; m_back[atag] = 0; m_err[atag] = 0;
         m_live[atag] = bus.alloc_rd != 0; m_rd[atag] = int'(bus.alloc_rd);
      end
      if (fire_w) m_ptr = (sel + 1) % DEPTH;
      m_lock     = sel >= 0 && !bus.wb_ready && !bus.flush;
      m_lock_tag = sel < 0 ? 0 : sel;
   endtask

   task automatic step();
      #1 check_outputs();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.alloc_valid = 0; bus.alloc_rd = 0; bus.rsp_valid = 0; bus.rsp_tag = 0;
      bus.rsp_err = 0; bus.wb_ready = 0; bus.rd_check = 0; bus.flush = 0;
`ifdef NBLOAD_STATS_EN
      bus.stats_clr = 0;
`endif
   endtask

   task automatic drain();
      idle(); bus.flush = 1; step();
      idle();
      for (int t = 0; t < DEPTH; t++)
         if (m_busy[t] && !m_back[t]) begin
            bus.rsp_valid = 1; bus.rsp_tag = TAG_W'(t); step();
         end
      idle();
      repeat (3) step();
      #1 chk("drain_free_cnt", bus.free_cnt, DEPTH);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1;
      model_reset();
      @(negedge clk);
      #1 chk("rst_alloc_ready", bus.alloc_ready, 1);
      chk("rst_alloc_tag", bus.alloc_tag, 0);
      chk("rst_free_cnt", bus.free_cnt, 8);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_unexp", bus.unexp_rsp, 0);
      step();
      rst = 0;

      // three allocations get tags 0,1,2
      for (int r = 5; r <= 7; r++) begin
         idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'(r);
         #1 chk("alloc_seq_tag", bus.alloc_tag, r - 5);
         step();
      end
      idle(); bus.rd_check = 6;
      #1 chk("free_after3", bus.free_cnt, 5);
      chk("rd_hit_6", bus.rd_hit, 1);
      step();

      // tag2 returns first and is locked while tag0 returns behind it
      idle(); bus.rsp_valid = 1; bus.rsp_tag = 2; step();
      idle(); bus.rsp_valid = 1; bus.rsp_tag = 0;
      #1 chk("first_wb_tag", bus.wb_tag, 2);
      step();
      repeat (3) begin
         idle();
         #1 chk("locked_wb_tag", bus.wb_tag, 2);
         chk("locked_wb_rd", bus.wb_rd, 7);
         step();
      end
      idle(); bus.wb_ready = 1; step();
      idle(); bus.wb_ready = 1;
      #1 chk("second_wb_tag", bus.wb_tag, 0);
      chk("second_wb_rd", bus.wb_rd, 5);
      step();

      // fill the table, then free tag 3 through writeback
      for (int k = 0; k < 7; k++) begin
         idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'(10 + k); step();
      end
      idle();
      #1 chk("full_ready", bus.alloc_ready, 0);
      chk("full_free_cnt", bus.free_cnt, 0);
      step();
      idle(); bus.rsp_valid = 1; bus.rsp_tag = 3; step();
      idle(); bus.wb_ready = 1;
      #1 chk("full_wb_tag", bus.wb_tag, 3);
      chk("no_same_cycle_reuse", bus.alloc_ready, 0);
      step();
      idle();
      #1 chk("reuse_ready", bus.alloc_ready, 1);
      chk("reuse_tag", bus.alloc_tag, 3);
      step();
      drain();

      // WAW kill: second load to rd9 cancels the first one's writeback
      idle(); bus.alloc_valid = 1; bus.alloc_rd = 9; step();
      idle(); bus.alloc_valid = 1; bus.alloc_rd = 9;
      #1 chk("waw_tag1", bus.alloc_tag, 1);
      step();
      idle(); bus.rsp_valid = 1; bus.rsp_tag = 0; step();
      idle();
      #1 chk("waw_no_wb", bus.wb_valid, 0);
      step();
      idle(); bus.rsp_valid = 1; bus.rsp_tag = 1;
      #1 chk("waw_freed", bus.free_cnt, 7);
      step();
      idle(); bus.wb_ready = 1;
      #1 chk("waw_wb_rd", bus.wb_rd, 9);
      step();
      drain();

      // flush with a response and an allocation in the same cycle
      idle(); bus.alloc_valid = 1; bus.alloc_rd = 3; step();
      idle(); bus.alloc_valid = 1; bus.alloc_rd = 4; step();
      idle(); bus.flush = 1; bus.rsp_valid = 1; bus.rsp_tag = 1; bus.alloc_valid = 1; bus.alloc_rd = 8;
      #1 chk("flush_blocks_alloc", bus.alloc_ready, 0);
      step();
      idle(); bus.rd_check = 3;
      #1 chk("flush_rd_hit", bus.rd_hit, 0);
      step();
      idle(); bus.rsp_valid = 1; bus.rsp_tag = 0; step();
      idle(); bus.wb_ready = 1; step();
      #1 chk("flush_all_free", bus.free_cnt, 8);

      // error response and an unexpected duplicate response
      for (int k = 0; k < 5; k++) begin
         idle(); bus.alloc_valid = 1; bus.alloc_rd = 5'(k + 1); step();
      end
      idle(); bus.rsp_valid = 1; bus.rsp_tag = 4; bus.rsp_err = 1; step();
      idle(); bus.rsp_valid = 1; bus.rsp_tag = 4;
      #1 chk("unexp_before", bus.unexp_rsp, 0);
      chk("err_wb_tag", bus.wb_tag, 4);
      chk("err_wb_err", bus.wb_err, 1);
      step();
      idle();
      #1 chk("unexp_pulse", bus.unexp_rsp, 1);
      step();
      idle();
      #1 chk("unexp_once", bus.unexp_rsp, 0);
      chk("err_kept", bus.wb_err, 1);
      step();
      drain();

      // random traffic with one mid-run reset
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            idle(); rst = 1; model_reset();
            step();
            rst = 0;
         end
         idle();
         bus.alloc_valid = $urandom_range(0, 1) == 1;
         bus.alloc_rd    = 5'($urandom_range(0, 7));
         bus.rd_check    = 5'($urandom_range(0, 7));
         bus.wb_ready    = $urandom_range(0, 9) < 6;
         bus.flush       = $urandom_range(0, 99) < 3;
         bus.rsp_err     = $urandom_range(0, 3) == 0;
         bus.rsp_valid   = $urandom_range(0, 2) != 0;
         pend.delete();
         for (int t = 0; t < DEPTH; t++) if (m_busy[t] && !m_back[t]) pend.push_back(t);
         if (pend.size() > 0 && $urandom_range(0, 9) < 7)
            bus.rsp_tag = TAG_W'(pend[$urandom_range(0, pend.size() - 1)]);
         else
            bus.rsp_tag = TAG_W'($urandom_range(0, DEPTH - 1));
         step();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
